// File: rtl/bp_me_pkg.sv
// Shared types and helpers for the LCE memory-engine control blocks.
package bp_me_pkg;

    // Busy controller FSM: normal operation, or forced busy after a port starves.
    typedef enum logic [0:0] {
        e_run     = 1'b0,
        e_holdoff = 1'b1
    } bp_lce_busy_state_e;

    // Counter width helper that never returns zero, so a 1-value range still gets a bit.
    function automatic int unsigned safe_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with a clear. Clear and up together yield 1 (clear, then count).
module bsg_counter_clear_up
    import bp_me_pkg::*;
#(
    parameter int max_val_p = 4,
    parameter int width_p   = safe_clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    // Count register; callers gate up_i so the count never passes max_val_p.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else begin
            count_o <= (clear_i ? '0 : count_o) + width_p'(up_i);
            a_no_overflow: assert (!(up_i && !clear_i && count_o == width_p'(max_val_p)));
        end
    end

endmodule

// File: rtl/bsg_counter_up_down.sv
// Saturating up/down counter in 0..max_val_p; simultaneous up and down cancel.
module bsg_counter_up_down
    import bp_me_pkg::*;
#(
    parameter int max_val_p = 8,
    parameter int width_p   = safe_clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o
);

    // Count register; an overflow or underflow request saturates and is flagged in simulation.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else begin
            if (up_i && !down_i && count_o != width_p'(max_val_p)) begin
                count_o <= count_o + width_p'(1);
            end else if (down_i && !up_i && count_o != '0) begin
                count_o <= count_o - width_p'(1);
            end
            a_no_inc_at_full:  assert (!(up_i && !down_i && count_o == width_p'(max_val_p)));
            a_no_dec_at_empty: assert (!(down_i && !up_i && count_o == '0));
        end
    end

endmodule

// File: rtl/bp_lce_busy_ctrl.sv
// LCE busy/throttle controller: combines credit state, engine readiness and
// per-port starvation detection into the cache request busy signal.
module bp_lce_busy_ctrl
    import bp_me_pkg::*;
#(
    parameter int ports_p               = 3,
    parameter int coh_noc_max_credits_p = 8,
    parameter int credits_p             = coh_noc_max_credits_p,
    parameter int timeout_max_limit_p   = 4,
    parameter int holdoff_max_p         = 8,
    localparam int lim_w_lp  = safe_clog2(timeout_max_limit_p + 1),
    localparam int cred_w_lp = safe_clog2(credits_p + 1),
    localparam int hold_w_lp = safe_clog2(holdoff_max_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [lim_w_lp-1:0] timeout_limit_i,
    input  logic [ports_p-1:0]  mem_pkt_v_i,
    input  logic [ports_p-1:0]  mem_pkt_yumi_i,
    input  logic                credit_inc_i,
    input  logic                credit_dec_i,
    input  logic                req_ready_i,
    input  logic                cmd_ready_i,
    output logic                cache_req_busy_o,
    output logic                credits_full_o,
    output logic                credits_empty_o,
    output logic                holdoff_o,
    output logic [ports_p-1:0]  starved_o
);

    logic [ports_p-1:0]   blocked;
    logic [ports_p-1:0]   timeout;
    logic [ports_p-1:0]   exit_clr;
    logic [ports_p-1:0]   cnt_clear;
    logic [ports_p-1:0]   cnt_up;
    logic [ports_p-1:0]   keep_mask;
    logic [ports_p-1:0]   new_timeout;
    logic [lim_w_lp-1:0]  limit_eff;
    logic [lim_w_lp-1:0]  port_cnt [ports_p];
    logic                 any_timeout;

    bp_lce_busy_state_e   state_q, state_n;
    logic [ports_p-1:0]   starved_q, starved_n;
    logic [hold_w_lp-1:0] hcnt_q, hcnt_n;
    logic [cred_w_lp-1:0] credit_cnt;

    // Out-of-range programmed limits clamp to the largest supported limit.
    assign limit_eff = (timeout_limit_i > lim_w_lp'(timeout_max_limit_p))
                     ? lim_w_lp'(timeout_max_limit_p) : timeout_limit_i;
    assign blocked   = mem_pkt_v_i & ~mem_pkt_yumi_i;

    // Per-port starvation counters. A count left above a newly lowered limit
    // still reads as timed out and simply holds.
    for (genvar g = 0; g < ports_p; g++) begin : g_port
        assign timeout[g]   = (limit_eff != '0) && (port_cnt[g] >= limit_eff);
        assign cnt_clear[g] = ~blocked[g] | exit_clr[g];
        assign cnt_up[g]    = blocked[g] & ~exit_clr[g] & (port_cnt[g] < limit_eff);

        bsg_counter_clear_up #(
            .max_val_p (timeout_max_limit_p),
            .width_p   (lim_w_lp)
        ) u_starve_cnt (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .clear_i (cnt_clear[g]),
            .up_i    (cnt_up[g]),
            .count_o (port_cnt[g])
        );
    end

    assign any_timeout = |timeout;
    // Only ports outside the current mask can start a fresh holdoff at exit.
    assign keep_mask   = starved_q & blocked;
    assign new_timeout = timeout & ~starved_q;

    bsg_counter_up_down #(
        .max_val_p (credits_p),
        .width_p   (cred_w_lp)
    ) u_credits (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .up_i    (credit_inc_i),
        .down_i  (credit_dec_i),
        .count_o (credit_cnt)
    );

    // State, starvation mask and holdoff countdown registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= e_run;
            starved_q <= '0;
            hcnt_q    <= '0;
        end else begin
            state_q   <= state_n;
            starved_q <= starved_n;
            hcnt_q    <= hcnt_n;
        end
    end

    // Next-state logic: enter holdoff on timeout, shrink the mask as ports
    // make progress, leave when the mask empties or the window expires.
    always_comb begin
        state_n   = state_q;
        starved_n = starved_q;
        hcnt_n    = hcnt_q;
        exit_clr  = '0;
        unique case (state_q)
            e_run: begin
                if (any_timeout) begin
                    state_n   = e_holdoff;
                    starved_n = timeout;
                    hcnt_n    = hold_w_lp'(holdoff_max_p - 1);
                end
            end
            e_holdoff: begin
                starved_n = keep_mask;
                if (keep_mask == '0 || hcnt_q == '0) begin
                    // Ports still starving restart their count from zero.
                    exit_clr = keep_mask;
                    if (new_timeout != '0) begin
                        starved_n = new_timeout;
                        hcnt_n    = hold_w_lp'(holdoff_max_p - 1);
                    end else begin
                        state_n   = e_run;
                        starved_n = '0;
                    end
                end else begin
                    hcnt_n = hcnt_q - hold_w_lp'(1);
                end
            end
            default: begin
                state_n   = e_run;
                starved_n = '0;
            end
        endcase
    end

    assign holdoff_o        = (state_q == e_holdoff);
    assign starved_o        = starved_q;
    assign credits_full_o   = (credit_cnt == cred_w_lp'(credits_p));
    assign credits_empty_o  = (credit_cnt == '0);
    assign cache_req_busy_o = credits_full_o | any_timeout | holdoff_o
                            | ~cmd_ready_i | ~req_ready_i;

endmodule

// File: doc/bp_lce_busy_ctrl.md
# bp_lce_busy_ctrl

Parametrised busy/throttle controller for a Local Cache/Coherence Engine. It decides when the LCE must refuse new cache requests by combining four inputs: outstanding-request credits, request/command engine readiness, and per-port starvation detection across any number of cache memory ports. When a port starves it holds the cache off for a bounded window. It sits between the LCE request/command engines and the cache, and drives `cache_req_busy_o` and the credit status outputs.

## Interface
- `ports_p`, 3: number of LCE→cache memory packet ports monitored (e.g. data/tag/stat); ≥1.
- `credits_p`, `coh_noc_max_credits_p`: maximum outstanding LCE requests; ≥1.
- `timeout_max_limit_p`, 4: largest programmable starvation limit.
- `holdoff_max_p`, 8: maximum cycles of forced busy once a port starves; ≥1.
- `clk_i`  in  1  clock; all state on rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `timeout_limit_i`  in  clog2(timeout_max_limit_p+1)  starvation limit; 0 disables detection; values above `timeout_max_limit_p` clamp to it.
- `mem_pkt_v_i`  in  ports_p  per-port LCE packet valid.
- `mem_pkt_yumi_i`  in  ports_p  per-port cache acceptance.
- `credit_inc_i`  in  1  LCE request handshake completed (one credit consumed).
- `credit_dec_i`  in  1  request completion (one credit returned).
- `req_ready_i`  in  1  request engine ready.
- `cmd_ready_i`  in  1  command engine ready (initialisation complete).
- `cache_req_busy_o`  out  1  cache must not issue a request.
- `credits_full_o`  out  1  credit count == credits_p.
- `credits_empty_o`  out  1  credit count == 0.
- `holdoff_o`  out  1  FSM is in HOLDOFF.
- `starved_o`  out  ports_p  latched mask of ports that triggered the current holdoff.

## Operation
- Blocked(p) = `mem_pkt_v_i[p] & ~mem_pkt_yumi_i[p]`. Per-port counter increments while blocked, clears to 0 when not blocked, and saturates at the effective limit.
- Timeout(p) = limit≠0 & count(p)==limit. `any_timeout` is the OR over ports. It is combinational and asserts busy in the same cycle.
- FSM states:
  - RUN: if `any_timeout`, latch `starved_o` = timeout mask, load holdoff counter with `holdoff_max_p-1`, and go to HOLDOFF.
  - HOLDOFF: each cycle, clear bits of `starved_o` whose port sees yumi or drops valid.
  - HOLDOFF exits to RUN when the mask becomes 0 or the holdoff counter reaches 0, whichever happens first. On exit, clear the counters of the ports still in the mask.
  - Ports not in the mask keep counting during HOLDOFF. A new timeout in the exit cycle re-enters HOLDOFF directly.
- Credits: up/down counter, 0..credits_p.
  - Simultaneous inc and dec: count unchanged.
  - inc at full saturates and is a simulation assertion error.
  - dec at empty saturates and is a simulation assertion error.
- `cache_req_busy_o` = credits_full | any_timeout | holdoff_o | ~cmd_ready_i | ~req_ready_i.

## Timing
- Reset values: FSM=RUN, all counters 0, `starved_o`=0, `holdoff_o`=0, `credits_full_o`=0, `credits_empty_o`=1. `cache_req_busy_o` = ~cmd_ready_i | ~req_ready_i (combinational even during reset).
- Starvation latency: with limit L, the port must be blocked for L consecutive cycles; busy rises combinationally in cycle L+1 of blocking and `holdoff_o` rises in the next cycle.
- Holdoff lasts at most `holdoff_max_p` cycles, then at least one RUN cycle follows unless a new timeout fires.
- Credit outputs are registered-count derived: an increment in cycle n is visible as full/empty in cycle n+1.
- Changing `timeout_limit_i` takes effect next compare; counters above the new limit count as timed out.
- Reset asserted mid-holdoff returns everything to reset values immediately.

## Structure
- `bp_lce_busy_state_e` (e_run, e_holdoff) belongs in `bp_me_pkg`.
- Natural sub-module: `bsg_counter_clear_up`, instanced per port via generate.
- Credits use `bsg_counter_up_down`.
- Holdoff counter and FSM are local.

## Test plan
- Reset with cmd_ready=0, req_ready=1 → busy=1, credits_empty=1. Then cmd_ready=1 → busy=0 in the same cycle.
- limit=4; port 1 v=1, yumi=0 for 6 cycles → busy in 5th cycle, holdoff_o=1 from 6th, starved_o=3'b010. Yumi in 7th cycle → RUN in 8th, busy=0.
- limit=2, holdoff_max=8; port 0 never yumi'd → holdoff lasts exactly 8 cycles, one RUN cycle, then re-entry after 2 blocked cycles (counter cleared on exit).
- credits_p=2: inc, inc → full=1, busy=1. Inc+dec same cycle → still full. Dec → full=0, busy=0.
- limit=0 with ports blocked for 100 cycles → busy never asserted by timeout, holdoff_o=0.
- Ports 0 and 2 time out in the same cycle → starved_o=3'b101. Port 0 yumi → 3'b100. Port 2 drops valid → RUN.
